// File: rtl/buffer_to_ddr3_pkg.sv
// buffer_to_ddr3_pkg: shared PSL mode encodings, DDR3 word geometry and write-formatter states
package buffer_to_ddr3_pkg;
  localparam int DDR3_W = 512;
  localparam int BE_W = 64;
  typedef enum logic [2:0] {
    MODE_NONE  = 3'b000,
    MEM_COPY   = 3'b001,
    DDR3_READ  = 3'b101,
    DDR3_WRITE = 3'b110
  } psl_mode_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE, FLUSH} b2d_state_t;
endpackage

// File: rtl/buffer_to_ddr3_fifo.sv
// buffer_to_ddr3_fifo: synchronous FIFO with head and head+1 lookahead so a consumer can pop and present the next entry in one cycle
module buffer_to_ddr3_fifo import buffer_to_ddr3_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int W = DDR3_W
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [W-1:0]             rdata_next,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  // pointer and occupancy update; clear wins over any push/pop
  always_comb begin
    full = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    do_push = push && !full && !clear;
    do_pop = pop && !empty && !clear;
    wr_d = clear ? '0 : wr_q + AW'(do_push);
    rd_d = clear ? '0 : rd_q + AW'(do_pop);
    cnt_d = clear ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    rdata = mem[rd_q];
    rdata_next = mem[rd_q + AW'(1)];
    count = cnt_q;
  end
  // storage array; contents are don't-care until written so it carries no reset
  always_ff @(posedge clk)
    if (do_push) mem[wr_q] <= wdata;
  // pointer and count registers
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/buffer_to_ddr3.sv
// buffer_to_ddr3: buffers 512-bit lines from the PSL write path and issues single-beat Avalon writes to DDR3
module buffer_to_ddr3 import buffer_to_ddr3_pkg::*; #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W = 30
) (
  input  logic                        clk,
  input  logic                        rstb,
  input  logic                        start,
  input  logic                        abort,
  input  logic [ADDR_W-1:0]           base_address,
  input  logic [31:0]                 num_lines,
  input  logic                        in_valid,
  input  logic [DDR3_W-1:0]           in_data,
  output logic                        in_ready,
  output logic [$clog2(FIFO_DEPTH):0] free_slots,
  output logic                        avl_write_req,
  output logic [ADDR_W-1:0]           avl_addr,
  output logic [DDR3_W-1:0]           avl_wdata,
  output logic [BE_W-1:0]             avl_be,
  output logic [2:0]                  avl_burstcount,
  input  logic                        avl_ready,
  output logic                        busy,
  output logic                        done,
  output logic [31:0]                 lines_written,
  output logic                        overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  b2d_state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] rem_in_q, rem_in_d, rem_out_q, rem_out_d, lines_q, lines_d;
  logic ovf_q, ovf_d, req_q, req_d;
  logic [DDR3_W-1:0] wdata_q, wdata_d, head, head_next;
  logic [CW-1:0] free_q, free_d, count;
  logic push, pop, clear, accept, full, empty;

  buffer_to_ddr3_fifo #(.DEPTH(FIFO_DEPTH), .W(DDR3_W)) u_fifo (
    .clk(clk), .rstb(rstb), .clear(clear), .push(push), .pop(pop), .wdata(in_data),
    .rdata(head), .rdata_next(head_next), .count(count), .full(full), .empty(empty)
  );

  // handshakes and the registered Avalon request: next beat is head+1 when the current one is taken
  always_comb begin
    accept = req_q && avl_ready;
    in_ready = state_q == RUN && !full && rem_in_q != '0;
    push = in_valid && in_ready;
    pop = accept;
    clear = state_q == FLUSH;
    free_d = clear ? CW'(FIFO_DEPTH) : CW'(FIFO_DEPTH) - count - CW'(push) + CW'(pop);
    req_d = state_q == RUN && !abort && !empty && !(pop && count == CW'(1));
    wdata_d = pop ? head_next : head;
  end

  // transfer control: start latches the job, accepted beats advance it, abort flushes
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rem_in_d = rem_in_q;
    rem_out_d = rem_out_q;
    lines_d = lines_q;
    ovf_d = ovf_q;
    if (state_q == IDLE && start) begin
      addr_d = base_address;
      rem_in_d = num_lines;
      rem_out_d = num_lines;
      lines_d = '0;
      ovf_d = 1'b0;
      state_d = num_lines == '0 ? DONE : RUN;
    end else if (state_q == RUN) begin
      rem_in_d = push ? rem_in_q - 32'd1 : rem_in_q;
      ovf_d = ovf_q || (in_valid && !in_ready);
      addr_d = accept ? addr_q + ADDR_W'(1) : addr_q;
      lines_d = accept ? lines_q + 32'd1 : lines_q;
      rem_out_d = accept ? rem_out_q - 32'd1 : rem_out_q;
      state_d = abort ? FLUSH : (accept && rem_out_q == 32'd1) ? DONE : RUN;
    end else if (state_q == DONE || state_q == FLUSH) begin
      state_d = IDLE;
    end
  end

  // state registers, asynchronously cleared so the request drops the moment reset asserts
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_in_q <= '0;
      rem_out_q <= '0;
      lines_q <= '0;
      ovf_q <= 1'b0;
      req_q <= 1'b0;
      wdata_q <= '0;
      free_q <= CW'(FIFO_DEPTH);
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_in_q <= rem_in_d;
      rem_out_q <= rem_out_d;
      lines_q <= lines_d;
      ovf_q <= ovf_d;
      req_q <= req_d;
      wdata_q <= wdata_d;
      free_q <= free_d;
    end

  assign free_slots = free_q;
  assign avl_write_req = req_q;
  assign avl_addr = addr_q;
  assign avl_wdata = wdata_q;
  assign avl_be = {BE_W{req_q}};
  assign avl_burstcount = 3'd1;
  assign busy = state_q == RUN || state_q == FLUSH;
  assign done = state_q == DONE;
  assign lines_written = lines_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_buffer_to_ddr3.sv
// tb_buffer_to_ddr3: directed scenarios for the DDR3 write formatter
module tb_buffer_to_ddr3;
  logic clk = 0, rstb = 1, start = 0, abort = 0, in_valid = 0, avl_ready = 0;
  logic [29:0] base_address = '0;
  logic [31:0] num_lines = '0;
  logic [511:0] in_data = '0;
  logic in_ready, avl_write_req, busy, done, overflow;
  logic [4:0] free_slots;
  logic [29:0] avl_addr;
  logic [511:0] avl_wdata;
  logic [63:0] avl_be;
  logic [2:0] avl_burstcount;
  logic [31:0] lines_written;
  int pass = 0, total = 0;

  buffer_to_ddr3 dut (
    .clk(clk), .rstb(rstb), .start(start), .abort(abort), .base_address(base_address),
    .num_lines(num_lines), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .free_slots(free_slots), .avl_write_req(avl_write_req), .avl_addr(avl_addr),
    .avl_wdata(avl_wdata), .avl_be(avl_be), .avl_burstcount(avl_burstcount),
    .avl_ready(avl_ready), .busy(busy), .done(done), .lines_written(lines_written),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] mk(input logic [15:0] t, input int i);
    return {16{t, i[15:0]}};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string nm);
    total++; if (avl_write_req !== 1'b0 || avl_addr !== '0 || avl_wdata !== '0 || avl_be !== '0) $display("FAIL %s_avl req=%b addr=%h be=%h exp 0", nm, avl_write_req, avl_addr, avl_be); else pass++;
    total++; if (free_slots !== 5'd16 || avl_burstcount !== 3'd1) $display("FAIL %s_free free=%0d burst=%0d exp 16/1", nm, free_slots, avl_burstcount); else pass++;
    total++; if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 || lines_written !== '0) $display("FAIL %s_status rdy=%b busy=%b done=%b ovf=%b lines=%0d exp all 0", nm, in_ready, busy, done, overflow, lines_written); else pass++;
  endtask

  task automatic do_xfer(input string nm, input logic [29:0] base, input int n, input logic [15:0] tag,
                         input int stall_beat, input int stall_len, input bit consec);
    int k, p, cyc, last, st;
    bit fin;
    logic [29:0] ea, ha;
    logic [511:0] hd;
    k = 0; p = 0; cyc = 0; last = -1; st = 0; fin = 0; ha = '0; hd = '0;
    base_address = base; num_lines = n; start = 1; avl_ready = 1;
    tick;
    start = 0;
    while (!fin && cyc < 300) begin
      total++; if (free_slots !== 5'(16 - (p - k))) $display("FAIL %s_free cyc%0d got %0d exp %0d", nm, cyc, free_slots, 16 - (p - k)); else pass++;
      if (done) begin
        fin = 1;
        total++; if (cyc != last + 1 || k != n || lines_written !== 32'(n)) $display("FAIL %s_done cyc=%0d beats=%0d lines=%0d exp cyc=%0d beats=lines=%0d", nm, cyc, k, lines_written, last + 1, n); else pass++;
      end else begin
        avl_ready = !(avl_write_req && k == stall_beat && st < stall_len);
        if (avl_write_req && st > 1 + (avl_ready ? -1 : 0) && k == stall_beat) begin
          total++; if (avl_addr !== ha || avl_wdata !== hd) $display("FAIL %s_hold addr=%h data=%h exp addr=%h data=%h", nm, avl_addr, avl_wdata[31:0], ha, hd[31:0]); else pass++;
        end
        if (avl_write_req && !avl_ready) begin
          if (st == 0) begin ha = avl_addr; hd = avl_wdata; end
          st++;
        end
        in_valid = in_ready && p < n;
        in_data = mk(tag, p);
        if (in_valid) p++;
        if (avl_write_req && avl_ready) begin
          ea = base + 30'(k);
          total++; if (k >= n || avl_addr !== ea || avl_wdata !== mk(tag, k) || avl_be !== '1 || (consec && k > 0 && cyc != last + 1)) $display("FAIL %s_beat%0d addr=%h data=%h be=%h cyc=%0d exp addr=%h data=%h cyc=%0d", nm, k, avl_addr, avl_wdata[31:0], avl_be[7:0], cyc, ea, mk(tag, k) & 512'hFFFFFFFF, last + 1); else pass++;
          k++;
          last = cyc;
        end
        tick;
        cyc++;
      end
    end
    in_valid = 0;
    avl_ready = 1;
    if (!fin) begin total++; $display("FAIL %s_timeout beats=%0d exp %0d", nm, k, n); end
    tick;
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL %s_pulse done=%b busy=%b exp 0/0", nm, done, busy); else pass++;
  endtask

  task automatic test_reset;
    #3 rstb = 0;
    #9;
    chk_idle_outputs("reset");
    @(negedge clk) rstb = 1;
    tick;
  endtask

  task automatic test_basic;
    do_xfer("basic", 30'h100, 4, 16'h00B1, -1, 0, 1);
  endtask

  task automatic test_backpressure;
    do_xfer("stall", 30'h2000, 6, 16'h00C2, 1, 5, 0);
  endtask

  task automatic test_full_fifo;
    int p = 0;
    base_address = '0; num_lines = 20; start = 1; avl_ready = 0;
    tick;
    start = 0;
    for (int c = 0; c < 30; c++) begin
      in_valid = in_ready && p < 20;
      in_data = mk(16'h00F0, p);
      if (in_valid) p++;
      tick;
    end
    in_valid = 0;
    total++; if (p != 16 || in_ready !== 1'b0) $display("FAIL full_accepted got %0d rdy=%b exp 16/0", p, in_ready); else pass++;
    total++; if (free_slots !== 5'd0) $display("FAIL full_free got %0d exp 0", free_slots); else pass++;
    total++; if (overflow !== 1'b0 || avl_write_req !== 1'b1) $display("FAIL full_ovf ovf=%b req=%b exp 0/1", overflow, avl_write_req); else pass++;
    in_valid = 1;
    tick;
    in_valid = 0;
    total++; if (overflow !== 1'b1) $display("FAIL full_forced_ovf got %b exp 1", overflow); else pass++;
    abort = 1;
    tick;
    abort = 0;
    tick;
    total++; if (busy !== 1'b0 || free_slots !== 5'd16 || overflow !== 1'b1) $display("FAIL full_cleanup busy=%b free=%0d ovf=%b exp 0/16/1", busy, free_slots, overflow); else pass++;
    avl_ready = 1;
  endtask

  task automatic test_abort;
    int p = 0;
    base_address = 30'h40; num_lines = 8; start = 1; avl_ready = 0;
    tick;
    start = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = in_ready && p < 3;
      in_data = mk(16'h00AA, p);
      if (in_valid) p++;
      tick;
    end
    in_valid = 0;
    total++; if (avl_write_req !== 1'b1 || free_slots !== 5'd13 || avl_addr !== 30'h40) $display("FAIL abort_pre req=%b free=%0d addr=%h exp 1/13/40", avl_write_req, free_slots, avl_addr); else pass++;
    abort = 1;
    tick;
    abort = 0;
    total++; if (avl_write_req !== 1'b0 || done !== 1'b0 || busy !== 1'b1) $display("FAIL abort_drop req=%b done=%b busy=%b exp 0/0/1", avl_write_req, done, busy); else pass++;
    tick;
    total++; if (free_slots !== 5'd16 || busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_flush free=%0d busy=%b done=%b exp 16/0/0", free_slots, busy, done); else pass++;
    tick;
    total++; if (done !== 1'b0 || lines_written !== '0) $display("FAIL abort_nodone done=%b lines=%0d exp 0/0", done, lines_written); else pass++;
    do_xfer("after_abort", 30'h500, 3, 16'h00AB, -1, 0, 1);
  endtask

  task automatic test_idle_ignores;
    in_valid = 1; abort = 1;
    tick;
    in_valid = 0; abort = 0;
    total++; if (overflow !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || free_slots !== 5'd16) $display("FAIL idle_ignore ovf=%b busy=%b rdy=%b free=%0d exp 0/0/0/16", overflow, busy, in_ready, free_slots); else pass++;
    base_address = 30'h600; num_lines = 1; start = 1; abort = 1;
    tick;
    start = 0; abort = 0;
    total++; if (busy !== 1'b1 || in_ready !== 1'b1) $display("FAIL start_wins busy=%b rdy=%b exp 1/1", busy, in_ready); else pass++;
    in_valid = 1; in_data = mk(16'h0060, 0); avl_ready = 1;
    for (int c = 0; c < 10 && !done; c++) begin
      tick;
      in_valid = 0;
    end
    total++; if (done !== 1'b1 || lines_written !== 32'd1) $display("FAIL start_wins_done done=%b lines=%0d exp 1/1", done, lines_written); else pass++;
    tick;
  endtask

  task automatic test_wrap_and_zero;
    do_xfer("wrap", 30'h3FFFFFFE, 3, 16'h00D3, -1, 0, 1);
    do_xfer("zero", 30'h123, 0, 16'h00E4, -1, 0, 1);
  endtask

  task automatic test_reset_mid;
    int p = 0;
    bit found = 0;
    base_address = 30'h700; num_lines = 4; start = 1; avl_ready = 1;
    tick;
    start = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (avl_write_req && avl_addr == 30'h701) found = 1;
      else begin
        in_valid = in_ready && p < 4;
        in_data = mk(16'h0707, p);
        if (in_valid) p++;
        tick;
      end
    end
    in_valid = 0;
    total++; if (!found) $display("FAIL rstmid_reach beat 2 never presented"); else pass++;
    #2 rstb = 0;
    #1;
    chk_idle_outputs("rstmid");
    @(negedge clk) rstb = 1;
    tick;
    do_xfer("after_reset", 30'h10, 2, 16'h0077, -1, 0, 1);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_full_fifo;
    test_abort;
    test_idle_ignores;
    test_wrap_and_zero;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/buffer_to_ddr3.md
Name: buffer_to_ddr3

Overview:
- Write-direction counterpart of the DDR3-to-buffer formatter, used in DDR3_WRITE mode.
- Accepts 512-bit lines that the PSL write-buffer path extracted from host memory and buffers them in a small FIFO.
- Issues single-beat Avalon-MM writes to the DDR3 controller at consecutive local addresses from a programmed base.
- Reports free FIFO slots to the command block so that read commands never outrun buffer space.

Parameters:
- FIFO_DEPTH, 16, number of 512-bit lines buffered; power of two, at least 4.
- ADDR_W, 30, DDR3 local address width; one address is one 512-bit word.

Ports:
- clk  in  1  clock, PSL pclock domain
- rstb  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; latches base_address and num_lines
- abort  in  1  one-cycle pulse; cancels the transfer
- base_address  in  ADDR_W  first DDR3 word address
- num_lines  in  32  number of 512-bit lines to write
- in_valid  in  1  in_data is valid this cycle
- in_data  in  512  line from the PSL buffer
- in_ready  out  1  line is accepted when in_valid && in_ready
- free_slots  out  $clog2(FIFO_DEPTH)+1  empty FIFO entries
- avl_write_req  out  1  Avalon write request
- avl_addr  out  ADDR_W  write address
- avl_wdata  out  512  write data
- avl_be  out  64  byte enables
- avl_burstcount  out  3  constant 1
- avl_ready  in  1  controller accepts the request when high
- busy  out  1  high in RUN or FLUSH
- done  out  1  one-cycle pulse when the last write is accepted
- lines_written  out  32  writes accepted in the current or last transfer
- overflow  out  1  sticky; set when in_valid is asserted while in_ready is low in RUN

Behaviour:
- Reset values: all outputs 0 except free_slots = FIFO_DEPTH and avl_burstcount = 1. FIFO is empty, state is IDLE.
- States:
  - IDLE: start with num_lines == 0 goes straight to DONE. start otherwise latches addr = base_address, remaining_in = num_lines, remaining_out = num_lines, clears lines_written and overflow, then goes to RUN. in_ready = 0.
  - RUN: in_ready = (FIFO not full) && (remaining_in != 0). Each accepted line is pushed and decrements remaining_in. Avalon side is described below. Acceptance of the final write (remaining_out going 1 -> 0) goes to DONE.
  - DONE: done = 1 for one cycle, then IDLE. lines_written holds its value until the next start.
  - FLUSH: entered on abort from RUN. Drops the request, empties the FIFO in one cycle, goes to IDLE. No done pulse.
- Avalon rules:
  - avl_write_req rises the cycle after the FIFO is non-empty. The request is registered from the FIFO head, with avl_be = all ones.
  - While avl_write_req && !avl_ready, avl_addr and avl_wdata are held stable and the request is not withdrawn, except on abort or reset.
  - Each accepted beat (req && ready) pops the FIFO, increments addr by 1 (wrapping modulo 2^ADDR_W), increments lines_written, and decrements remaining_out.
  - The next beat is presented in the same cycle as the acceptance when the FIFO holds another entry, giving one write per clock at steady state.
- FIFO:
  - A simultaneous push and pop leaves the count unchanged.
  - Push while full is impossible through in_ready. A violating in_valid sets overflow and the data is dropped.
  - free_slots is registered and reflects the count after the current cycle's push and pop.
- Other edge cases:
  - in_valid in IDLE, DONE or FLUSH is ignored and does not set overflow.
  - start outside IDLE is ignored.
  - abort in IDLE or DONE is ignored.
  - abort and start in the same cycle in IDLE: start wins.
  - Asynchronous reset mid-transfer: the request is dropped immediately and all state returns to reset values.

Decomposition:
- Shared package (pslPkg): mode encodings (DDR3_WRITE = 'b110 and the others), DDR3 word width 512, byte-enable width 64, and the state enum for this block.
- Sub-module syncFifo512: parameterised synchronous FIFO with push, pop, data, count, full and empty signals. It is also reusable by the read path.

Test Plan:
- Basic transfer: base_address = 0x100, num_lines = 4, four lines pushed back-to-back, avl_ready = 1.
  - Writes go to 0x100..0x103 with matching data on consecutive cycles.
  - done fires one cycle after the last acceptance; lines_written = 4.
- Backpressure: avl_ready held low for 5 cycles during the second beat.
  - avl_addr and avl_wdata stay stable throughout the stall.
  - No beat is duplicated or lost; free_slots drops accordingly.
- Full FIFO: FIFO_DEPTH = 16 with avl_ready = 0 and 20 lines offered.
  - in_ready falls after 16 lines; free_slots = 0; overflow stays 0 when the source honours in_ready.
  - A forced in_valid while full sets overflow.
- Address wrap and zero length:
  - base_address = 0x3FFFFFFE, num_lines = 3 gives addresses 0x3FFFFFFE, 0x3FFFFFFF, 0x0.
  - num_lines = 0 gives done one cycle after start, with no write issued.
- Abort mid-stall: abort while avl_write_req is high and 3 lines are queued.
  - The request drops the next cycle; free_slots returns to FIFO_DEPTH; no done pulse.
  - A subsequent start then runs a clean transfer.
- Reset mid-transfer: rstb asserted during beat 2.
  - All outputs return to their reset values asynchronously; the FIFO is empty after release.
